// File: rtl/rgb_set_batcher.sv
// Groups completed RGB sets into batches, offers each one to a consumer and holds it until ack.
// Define BATCH_TIMEOUT_EN to flush a partly filled batch after TIMEOUT_CYC cycles with no det.
module rgb_set_batcher #(
  parameter int BATCH_SIZE  = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       det,
  input  logic       clr,
  input  logic       ack,
  output logic       batch_req,
  output logic [3:0] set_cnt,
  output logic [7:0] batch_cnt,
  output logic       ovf,
  output logic       partial
);

  if (BATCH_SIZE < 2 || BATCH_SIZE > 15 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_param_chk
    $error("rgb_set_batcher: BATCH_SIZE or TIMEOUT_CYC out of range");
  end

  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

  localparam logic [3:0] BS    = 4'(BATCH_SIZE);
  localparam logic [3:0] BS_M1 = 4'(BATCH_SIZE - 1);

  state_t     state, state_nxt;
  logic [3:0] set_cnt_nxt, pend, pend_nxt;
  logic [7:0] batch_cnt_nxt;
  logic       ovf_nxt, batch_req_nxt;

`ifdef BATCH_TIMEOUT_EN
  localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT_CYC - 1);
  logic [7:0] tmo, tmo_nxt;
  logic       tmo_hit, partial_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      set_cnt   <= '0;
      pend      <= '0;
      batch_cnt <= '0;
      ovf       <= 1'b0;
      batch_req <= 1'b0;
`ifdef BATCH_TIMEOUT_EN
      tmo       <= '0;
      partial   <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      set_cnt   <= set_cnt_nxt;
      pend      <= pend_nxt;
      batch_cnt <= batch_cnt_nxt;
      ovf       <= ovf_nxt;
      batch_req <= batch_req_nxt;
`ifdef BATCH_TIMEOUT_EN
      tmo       <= tmo_nxt;
      partial   <= partial_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt     = state;
    set_cnt_nxt   = set_cnt;
    pend_nxt      = pend;
    batch_cnt_nxt = batch_cnt;
    ovf_nxt       = ovf;
`ifdef BATCH_TIMEOUT_EN
    tmo_nxt       = tmo;
    tmo_hit       = 1'b0;
`endif
    if (clr) begin
      state_nxt   = IDLE;
      set_cnt_nxt = '0;
      pend_nxt    = '0;
      ovf_nxt     = 1'b0;
`ifdef BATCH_TIMEOUT_EN
      tmo_nxt     = '0;
`endif
    end else begin
      case (state)
        IDLE, FILL: begin
          if (det) begin
            set_cnt_nxt = set_cnt + 4'd1;
            state_nxt   = (set_cnt + 4'd1 == BS) ? HOLD : FILL;
`ifdef BATCH_TIMEOUT_EN
            tmo_nxt     = TMO_LOAD;
          end else if (state == FILL) begin
            // down-counter reaches zero on the TIMEOUT_CYC-th idle cycle
            if (tmo == 8'd0) begin
              tmo_hit   = 1'b1;
              state_nxt = HOLD;
            end else begin
              tmo_nxt   = tmo - 8'd1;
            end
`endif
          end
        end
        HOLD: begin
          if (ack) begin
            batch_cnt_nxt = batch_cnt + 8'd1;
            set_cnt_nxt   = pend + {3'b000, det};
            pend_nxt      = '0;
            if (pend + {3'b000, det} == 4'd0) state_nxt = IDLE;
            else if (pend + {3'b000, det} < BS) state_nxt = FILL;
            else state_nxt = HOLD;
`ifdef BATCH_TIMEOUT_EN
            tmo_nxt       = TMO_LOAD;
`endif
          end else if (det) begin
            if (pend == BS_M1) ovf_nxt = 1'b1;
            else pend_nxt = pend + 4'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    batch_req_nxt = (state_nxt == HOLD);
`ifdef BATCH_TIMEOUT_EN
    partial_nxt = partial;
    // a batch re-offered straight after ack is always a full one
    if (state_nxt != HOLD || (state == HOLD && ack)) partial_nxt = 1'b0;
    if (tmo_hit) partial_nxt = 1'b1;
`endif
  end

`ifndef BATCH_TIMEOUT_EN
  assign partial = 1'b0;
`endif

endmodule

// File: tb/tb_rgb_set_batcher.sv
// Directed test of rgb_set_batcher (BATCH_SIZE=4, TIMEOUT_CYC=16) with hand-computed expectations.
module tb_rgb_set_batcher;

  logic       clk = 1'b0;
  logic       rst, det, clr, ack;
  logic       batch_req, ovf, partial;
  logic [3:0] set_cnt;
  logic [7:0] batch_cnt;
  int         n_chk  = 0;
  int         n_pass = 0;

  rgb_set_batcher #(.BATCH_SIZE(4), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .det(det), .clr(clr), .ack(ack),
    .batch_req(batch_req), .set_cnt(set_cnt), .batch_cnt(batch_cnt),
    .ovf(ovf), .partial(partial)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_det(input int n);
    repeat (n) begin
      det = 1'b1; tick(); det = 1'b0;
    end
  endtask

  task automatic do_ack();
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; det = 1'b0; clr = 1'b0; ack = 1'b0;
    tick(2);
    rst = 1'b0;
    chk("rst_set_cnt", set_cnt, 0);
    chk("rst_batch_req", batch_req, 0);
    chk("rst_batch_cnt", batch_cnt, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_partial", partial, 0);

    // four dets spaced 3 cycles, ack two cycles after the offer
    for (int i = 1; i <= 4; i++) begin
      pulse_det(1);
      chk($sformatf("fill_set_cnt_%0d", i), set_cnt, i);
      chk($sformatf("fill_req_%0d", i), batch_req, (i == 4) ? 1 : 0);
      tick(2);
    end
    chk("hold_req_kept", batch_req, 1);
    do_ack();
    chk("ack_req", batch_req, 0);
    chk("ack_batch_cnt", batch_cnt, 1);
    chk("ack_set_cnt", set_cnt, 0);

    // ack outside HOLD is ignored
    do_ack();
    chk("stray_ack_batch_cnt", batch_cnt, 1);

    // overflow: 3 pending dets fit, the 4th is dropped
    pulse_det(4);
    chk("ovf_hold_req", batch_req, 1);
    pulse_det(3);
    chk("ovf_before", ovf, 0);
    chk("ovf_hold_set_cnt", set_cnt, 4);
    pulse_det(1);
    chk("ovf_set", ovf, 1);
    tick(2);
    chk("ovf_sticky", ovf, 1);
    do_ack();
    chk("ovf_ack_set_cnt", set_cnt, 3);
    chk("ovf_ack_req", batch_req, 0);
    chk("ovf_ack_batch_cnt", batch_cnt, 2);
    chk("ovf_after_ack", ovf, 1);
    pulse_det(1);
    chk("fill_from_pend_req", batch_req, 1);
    chk("fill_from_pend_cnt", set_cnt, 4);

    // pend=3 then det together with ack: refilled batch stays offered
    pulse_det(3);
    det = 1'b1; ack = 1'b1; tick(); det = 1'b0; ack = 1'b0;
    chk("detack_set_cnt", set_cnt, 4);
    chk("detack_req", batch_req, 1);
    chk("detack_batch_cnt", batch_cnt, 3);
    do_ack();
    chk("drain_set_cnt", set_cnt, 0);
    chk("drain_batch_cnt", batch_cnt, 4);

    // clr wins over det, keeps batch_cnt
    pulse_det(2);
    clr = 1'b1; det = 1'b1; tick(); clr = 1'b0; det = 1'b0;
    chk("clr_set_cnt", set_cnt, 0);
    chk("clr_ovf", ovf, 0);
    chk("clr_batch_cnt", batch_cnt, 4);

    // clr mid-HOLD drops the offer, ack in that cycle is ignored
    pulse_det(4);
    clr = 1'b1; ack = 1'b1; tick(); clr = 1'b0; ack = 1'b0;
    chk("clr_hold_req", batch_req, 0);
    chk("clr_hold_batch_cnt", batch_cnt, 4);

    // batch counter wrap
    repeat (251) begin
      pulse_det(4);
      do_ack();
    end
    chk("batch_cnt_255", batch_cnt, 255);
    pulse_det(4);
    do_ack();
    chk("batch_cnt_wrap", batch_cnt, 0);
    pulse_det(4);
    do_ack();
    chk("batch_cnt_after_wrap", batch_cnt, 1);

    // rst mid-HOLD beats ack
    pulse_det(4);
    rst = 1'b1; ack = 1'b1; tick(); rst = 1'b0; ack = 1'b0;
    chk("rst_hold_batch_cnt", batch_cnt, 0);
    chk("rst_hold_req", batch_req, 0);
    chk("rst_hold_set_cnt", set_cnt, 0);

    // rst mid-FILL
    pulse_det(2);
    chk("prefill_set_cnt", set_cnt, 2);
    rst = 1'b1; det = 1'b1; tick(); rst = 1'b0; det = 1'b0;
    chk("rst_fill_set_cnt", set_cnt, 0);
    chk("rst_fill_req", batch_req, 0);
    chk("rst_fill_ovf", ovf, 0);

    // partial-batch timeout
    pulse_det(2);
`ifdef BATCH_TIMEOUT_EN
    tick(15);
    chk("tmo_not_yet_req", batch_req, 0);
    tick();
    chk("tmo_req", batch_req, 1);
    chk("tmo_partial", partial, 1);
    chk("tmo_set_cnt", set_cnt, 2);
    do_ack();
    chk("tmo_ack_partial", partial, 0);
    chk("tmo_ack_req", batch_req, 0);
    chk("tmo_ack_batch_cnt", batch_cnt, 1);
    chk("tmo_ack_set_cnt", set_cnt, 0);
`else
    tick(40);
    chk("no_tmo_req", batch_req, 0);
    chk("no_tmo_partial", partial, 0);
    chk("no_tmo_set_cnt", set_cnt, 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rgb_set_batcher.md
RGB_SET_BATCHER -- requirements
Module: rgb_set_batcher

Interface
REQ-001 SHALL have parameter BATCH_SIZE, default 4, meaning completed RGB sets per batch (legal 2..15).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 16, meaning idle cycles before a partial-batch flush (legal 2..255; used only under REQ-024).
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port det, input, 1 bit: one-cycle pulse from the upstream RGB sequence detector, marking one completed RGB set.
REQ-006 SHALL have port clr, input, 1 bit: synchronous soft clear.
REQ-007 SHALL have port ack, input, 1 bit: consumer accepts the offered batch.
REQ-008 SHALL have port batch_req, output, 1 bit: a batch is offered; held until ack.
REQ-009 SHALL have port set_cnt, output, 4 bits: sets in the batch being filled or offered.
REQ-010 SHALL have port batch_cnt, output, 8 bits: batches accepted since reset.
REQ-011 SHALL have port ovf, output, 1 bit: sticky flag, a det was dropped.
REQ-012 SHALL have port partial, output, 1 bit: the offered batch is a timeout flush.

Function
REQ-013 SHALL implement FSM states IDLE (set_cnt=0), FILL (0<set_cnt<BATCH_SIZE) and HOLD (batch_req=1); all outputs SHALL be registered.
REQ-014 IDLE/FILL: det=1 SHALL increment set_cnt next cycle; reaching BATCH_SIZE SHALL enter HOLD, with batch_req=1 in the same cycle set_cnt=BATCH_SIZE.
REQ-015 HOLD: set_cnt and batch_req SHALL hold until ack=1; ack outside HOLD SHALL be ignored.
REQ-016 HOLD: det=1 without ack SHALL increment an internal pending counter pend (max BATCH_SIZE-1).
REQ-017 HOLD with pend=BATCH_SIZE-1, det=1, ack=0: det SHALL be dropped and ovf SHALL set next cycle, remaining 1 until rst or clr.
REQ-018 HOLD with ack=1: batch_cnt SHALL increment (wrap 255->0); set_cnt SHALL load pend+det; pend SHALL clear; next state IDLE if the new set_cnt is 0, FILL if below BATCH_SIZE, else HOLD with batch_req staying 1.
REQ-019 Latency: det to set_cnt update is 1 cycle; final det to batch_req=1 is 1 cycle; ack to batch_req=0 is 1 cycle.
REQ-020 clr=1 SHALL, next cycle, force IDLE and zero set_cnt, pend, batch_req, partial and ovf; batch_cnt SHALL be retained; det and ack in that cycle SHALL be ignored.

Reset
REQ-021 rst=1 SHALL, next cycle, force IDLE and drive batch_req=0, set_cnt=0, batch_cnt=0, ovf=0, partial=0, pend=0 and timeout counter 0.
REQ-022 rst SHALL override clr, det and ack, including mid-HOLD; no batch_cnt increment SHALL occur in that cycle.
REQ-023 Priority: rst > clr > ack > det.

Configuration
REQ-024 With BATCH_TIMEOUT_EN defined: in FILL, a counter SHALL count cycles without det, restarting on each det; reaching TIMEOUT_CYC SHALL enter HOLD with batch_req=1, partial=1 and set_cnt unchanged; partial SHALL clear on the cycle batch_req clears.
REQ-025 Without BATCH_TIMEOUT_EN: there SHALL be no timeout logic, partial SHALL be constant 0, and FILL SHALL persist indefinitely.

Verification
REQ-026 BATCH_SIZE=4; 4 det pulses spaced 3 cycles; ack 2 cycles later -> set_cnt 1,2,3,4; batch_req=1 one cycle after 4th det; batch_cnt=1 and set_cnt=0 after ack.
REQ-027 In HOLD, 3 det pulses without ack, then a 4th -> ovf=1 sticky; on ack, set_cnt=3 and state FILL.
REQ-028 In HOLD with pend=3: det and ack in the same cycle -> set_cnt=4, batch_req stays 1, batch_cnt increments by 1.
REQ-029 batch_cnt=255 and one more accepted batch -> batch_cnt=0; then rst asserted mid-FILL -> all outputs at reset values next cycle.
REQ-030 BATCH_TIMEOUT_EN, TIMEOUT_CYC=16: 2 det then silence -> batch_req=1 and partial=1 with set_cnt=2 after 16 idle cycles; ack -> partial=0, batch_cnt=1; without the macro, partial never asserts.
